// File: rtl/controller_seq.sv
// VeriRisc control unit: owns an 8-phase sequencer and decodes opcode, phase and
// the accumulator zero flag into the datapath/memory strobes.
//
// state     | meaning
// PH_FETCH0 | drive PC address to memory
// PH_ADDR   | memory output enabled, instruction on bus
// PH_IR0    | load instruction register
// PH_IR1    | load IR; holds here until the fetch completes (mem_rdy)
// PH_INC    | increment PC; HLT raises halt and parks the machine
// PH_EX0    | execute, operand address phase
// PH_EX1    | execute, operand/data phase
// PH_EX2    | execute, completion; memory ops hold until mem_rdy
module controller_seq #(
  parameter int OPW     = 3,
  parameter bit WAIT_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_rdy,
  input  logic           resume,
  output logic           sel,
  output logic           rd,
  output logic           ld_ir,
  output logic           inc_pc,
  output logic           halt,
  output logic           ld_pc,
  output logic           data_e,
  output logic           ld_ac,
  output logic           wr,
  output logic [2:0]     phase,
  output logic           halted,
  output logic           cycle_done
);

  typedef enum logic [2:0] {
    PH_FETCH0 = 3'd0,
    PH_ADDR   = 3'd1,
    PH_IR0    = 3'd2,
    PH_IR1    = 3'd3,
    PH_INC    = 3'd4,
    PH_EX0    = 3'd5,
    PH_EX1    = 3'd6,
    PH_EX2    = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_t     phase_q, phase_d;
  logic       halted_q, halted_d;
  logic       rsvd;
  logic [2:0] op;
  logic       is_alu, is_sto, is_jmp, is_skz, is_hlt;
  logic       stall, advance;

  generate
    if (OPW > 3) begin : g_rsvd
      assign rsvd = |opcode[OPW-1:3];
    end else begin : g_no_rsvd
      assign rsvd = 1'b0;
    end
  endgenerate

  // Reserved opcodes fetch normally but never qualify as any executable class.
  assign op     = opcode[2:0];
  assign is_alu = !rsvd && (op == OP_ADD || op == OP_AND || op == OP_XOR || op == OP_LDA);
  assign is_sto = !rsvd && (op == OP_STO);
  assign is_jmp = !rsvd && (op == OP_JMP);
  assign is_skz = !rsvd && (op == OP_SKZ);
  assign is_hlt = !rsvd && (op == OP_HLT);

  always_comb begin
    phase_d    = phase_q;
    halted_d   = halted_q;
    stall      = 1'b0;
    sel        = 1'b0;
    rd         = 1'b0;
    ld_ir      = 1'b0;
    inc_pc     = 1'b0;
    halt       = 1'b0;
    ld_pc      = 1'b0;
    data_e     = 1'b0;
    ld_ac      = 1'b0;
    wr         = 1'b0;

    if (WAIT_EN && !mem_rdy) begin
      stall = (phase_q == PH_IR1) || (phase_q == PH_EX2 && (is_alu || is_sto));
    end
    advance = en && !halted_q && !stall;

    if (halted_q) begin
      if (resume) begin
        halted_d = 1'b0;
        phase_d  = PH_FETCH0;
      end
    end else if (advance) begin
      phase_d = phase_t'(phase_q + 3'd1);
      if (phase_q == PH_INC && is_hlt) halted_d = 1'b1;
    end

    cycle_done = rst && advance && (phase_q == PH_EX2);

    // Strobes are gated by reset so nothing fires while the async reset is held.
    if (rst && !halted_q) begin
      case (phase_q)
        PH_FETCH0: sel = 1'b1;
        PH_ADDR: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_IR0, PH_IR1: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_INC: begin
          inc_pc = 1'b1;
          halt   = is_hlt;
        end
        PH_EX0: rd = is_alu;
        PH_EX1: begin
          rd     = is_alu;
          data_e = is_sto;
          ld_pc  = is_jmp;
          inc_pc = is_skz && zero;
        end
        PH_EX2: begin
          rd     = is_alu;
          ld_ac  = is_alu;
          data_e = is_sto;
          wr     = is_sto;
          ld_pc  = is_jmp;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= PH_FETCH0;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  assign phase  = phase_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_controller_seq.sv
// Bench for controller_seq: a wait-state instance and a no-wait instance driven
// in lockstep, checked against literal vectors and a behavioural model.
module tb_controller_seq;
  localparam int OPW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, en, zero, mem_rdy, resume;
  logic [OPW-1:0] opcode;
  wire  [8:0]     st_w, st_n;
  wire  [2:0]     ph_w, ph_n;
  wire            hl_w, hl_n, cd_w, cd_n;

  controller_seq #(.OPW(OPW), .WAIT_EN(1'b1)) dut_w (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .zero(zero),
    .mem_rdy(mem_rdy), .resume(resume),
    .sel(st_w[8]), .rd(st_w[7]), .ld_ir(st_w[6]), .inc_pc(st_w[5]), .halt(st_w[4]),
    .ld_pc(st_w[3]), .data_e(st_w[2]), .ld_ac(st_w[1]), .wr(st_w[0]),
    .phase(ph_w), .halted(hl_w), .cycle_done(cd_w));

  controller_seq #(.OPW(OPW), .WAIT_EN(1'b0)) dut_n (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .zero(zero),
    .mem_rdy(mem_rdy), .resume(resume),
    .sel(st_n[8]), .rd(st_n[7]), .ld_ir(st_n[6]), .inc_pc(st_n[5]), .halt(st_n[4]),
    .ld_pc(st_n[3]), .data_e(st_n[2]), .ld_ac(st_n[1]), .wr(st_n[0]),
    .phase(ph_n), .halted(hl_n), .cycle_done(cd_n));

  int n_chk = 0;
  int n_err = 0;

  // Model state: index 0 = wait-state instance, 1 = no-wait instance.
  int m_ph[2];
  bit m_hl[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] exp_st(int ph, bit hl, logic [3:0] op, bit z, bit r);
    logic [8:0] v;
    int k;
    bit rs;
    v  = '0;
    k  = int'(op[2:0]);
    rs = op[3];
    if (!r || hl) return '0;
    case (ph)
      0: v = 9'b100000000;
      1: v = 9'b110000000;
      2, 3: v = 9'b111000000;
      4: v = (k == 0 && !rs) ? 9'b000110000 : 9'b000100000;
      default: begin
        if (!rs) begin
          if (k >= 2 && k <= 5) v = (ph == 7) ? 9'b010000010 : 9'b010000000;
          else if (k == 6) v = (ph == 5) ? 9'b0 : ((ph == 6) ? 9'b000000100 : 9'b000000101);
          else if (k == 7) v = (ph == 5) ? 9'b0 : 9'b000001000;
          else if (k == 1) v = (ph == 6 && z) ? 9'b000100000 : 9'b0;
        end
      end
    endcase
    return v;
  endfunction

  function automatic bit m_stall(int i);
    int k;
    k = int'(opcode[2:0]);
    if (i != 0 || mem_rdy) return 1'b0;
    return (m_ph[i] == 3) || (m_ph[i] == 7 && !opcode[3] && k >= 2 && k <= 6);
  endfunction

  function automatic bit m_adv(int i);
    return en && !m_hl[i] && !m_stall(i);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = 0;
      m_hl[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit adv;
    for (int i = 0; i < 2; i++) begin
      adv = m_adv(i);
      if (!rst) begin
        m_ph[i] = 0;
        m_hl[i] = 1'b0;
      end else if (m_hl[i]) begin
        if (resume) begin
          m_hl[i] = 1'b0;
          m_ph[i] = 0;
        end
      end else if (adv) begin
        if (m_ph[i] == 4 && opcode[2:0] == 3'd0 && !opcode[3]) m_hl[i] = 1'b1;
        m_ph[i] = (m_ph[i] + 1) % 8;
      end
    end
  endtask

  task automatic check_all();
    logic [8:0] a;
    logic [2:0] p;
    logic       h, c;
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? st_w : st_n;
      p = (i == 0) ? ph_w : ph_n;
      h = (i == 0) ? hl_w : hl_n;
      c = (i == 0) ? cd_w : cd_n;
      chk($sformatf("model strobes[%0d]", i), 32'(a), 32'(exp_st(m_ph[i], m_hl[i], opcode, zero, rst)));
      chk($sformatf("model phase[%0d]", i), 32'(p), 32'(m_ph[i]));
      chk($sformatf("model halted[%0d]", i), 32'(h), 32'(m_hl[i]));
      chk($sformatf("model cycle_done[%0d]", i), 32'(c), 32'(rst && m_adv(i) && m_ph[i] == 7));
    end
  endtask

  task automatic drive(input bit r, input bit e, input logic [3:0] op, input bit z,
                       input bit rdy, input bit res);
    rst = r; en = e; opcode = op; zero = z; mem_rdy = rdy; resume = res;
    if (!r) model_reset();
    #1;
    check_all();
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input bit r, input bit e, input logic [3:0] op, input bit z,
                      input bit rdy, input bit res);
    drive(r, e, op, z, rdy, res);
    clk_edge();
  endtask

  typedef struct {
    logic [3:0]      op;
    bit              z;
    logic [7:0][8:0] exp;
  } vec_t;

  localparam logic [44:0] FETCH = {9'b000100000, 9'b111000000, 9'b111000000,
                                   9'b110000000, 9'b100000000};

  vec_t tbl[7];
  int   len_w, len_n;

  initial begin
    tbl[0] = '{op: 4'd2, z: 1'b0, exp: {9'b010000010, 9'b010000000, 9'b010000000, FETCH}};
    tbl[1] = '{op: 4'd6, z: 1'b0, exp: {9'b000000101, 9'b000000100, 9'b000000000, FETCH}};
    tbl[2] = '{op: 4'd7, z: 1'b0, exp: {9'b000001000, 9'b000001000, 9'b000000000, FETCH}};
    tbl[3] = '{op: 4'd1, z: 1'b1, exp: {9'b000000000, 9'b000100000, 9'b000000000, FETCH}};
    tbl[4] = '{op: 4'd1, z: 1'b0, exp: {9'b000000000, 9'b000000000, 9'b000000000, FETCH}};
    tbl[5] = '{op: 4'd5, z: 1'b1, exp: {9'b010000010, 9'b010000000, 9'b010000000, FETCH}};
    tbl[6] = '{op: 4'b1010, z: 1'b0, exp: {9'b000000000, 9'b000000000, 9'b000000000, FETCH}};

    model_reset();
    drive(1'b0, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0);
    chk("reset strobes", 32'(st_w), 32'd0);
    chk("reset phase", 32'(ph_w), 32'd0);
    clk_edge();
    clk_edge();

    // Literal per-phase strobe vectors, one instruction per table row.
    for (int t = 0; t < 7; t++) begin
      for (int p = 0; p < 8; p++) begin
        drive(1'b1, 1'b1, tbl[t].op, tbl[t].z, 1'b1, 1'b0);
        chk($sformatf("tbl%0d ph%0d strobes_w", t, p), 32'(st_w), 32'(tbl[t].exp[p]));
        chk($sformatf("tbl%0d ph%0d strobes_n", t, p), 32'(st_n), 32'(tbl[t].exp[p]));
        chk($sformatf("tbl%0d ph%0d phase", t, p), 32'(ph_w), 32'(p));
        chk($sformatf("tbl%0d ph%0d cycle_done", t, p), 32'(cd_w), 32'(p == 7));
        chk($sformatf("tbl%0d ph%0d halted", t, p), 32'(hl_w), 32'd0);
        clk_edge();
      end
    end

    // Async reset in the middle of STO at phase 5.
    for (int p = 0; p < 5; p++) step(1'b1, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0);
    chk("sto pre-reset phase", 32'(ph_w), 32'd5);
    drive(1'b0, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0);
    chk("sto reset phase", 32'(ph_w), 32'd0);
    chk("sto reset strobes", 32'(st_w), 32'd0);
    chk("sto reset wr", 32'(st_w[0]), 32'd0);
    clk_edge();
    for (int p = 0; p < 8; p++) begin
      drive(1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
      chk($sformatf("post-reset phase %0d", p), 32'(ph_w), 32'(p));
      if (p == 0) chk("post-reset sel", 32'(st_w[8]), 32'd1);
      clk_edge();
    end

    // LDA with wait states: 3 stalls at phase 3, 2 stalls at phase 7.
    len_w = -1;
    len_n = -1;
    for (int c = 0; c < 13; c++) begin
      drive(1'b1, 1'b1, 4'd5, 1'b0, !(c inside {3, 4, 5, 10, 11}), 1'b0);
      if (c inside {3, 4, 5}) begin
        chk("lda fetch stall phase", 32'(ph_w), 32'd3);
        chk("lda fetch stall ld_ir", 32'(st_w[6]), 32'd1);
      end
      if (c inside {10, 11}) begin
        chk("lda exec stall phase", 32'(ph_w), 32'd7);
        chk("lda exec stall ld_ac", 32'(st_w[1]), 32'd1);
        chk("lda exec stall cycle_done", 32'(cd_w), 32'd0);
      end
      if (cd_w && len_w < 0) len_w = c + 1;
      if (cd_n && len_n < 0) len_n = c + 1;
      clk_edge();
    end
    chk("lda length wait", 32'(len_w), 32'd13);
    chk("lda length nowait", 32'(len_n), 32'd8);
    step(1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0);

    // HLT, ten idle clocks with en=1, then resume.
    for (int p = 0; p < 4; p++) step(1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    chk("hlt phase4 strobes", 32'(st_w), 32'(9'b000110000));
    clk_edge();
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
      chk("halted flag", 32'(hl_w), 32'd1);
      chk("halted phase", 32'(ph_w), 32'd5);
      chk("halted strobes", 32'(st_w), 32'd0);
      clk_edge();
    end
    step(1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
    chk("resume phase", 32'(ph_w), 32'd0);
    chk("resume halted", 32'(hl_w), 32'd0);
    chk("resume sel", 32'(st_w[8]), 32'd1);

    // JMP must not stall at phase 7 with mem_rdy=0.
    for (int p = 0; p < 7; p++) step(1'b1, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    chk("jmp ph7 cycle_done", 32'(cd_w), 32'd1);
    clk_edge();
    drive(1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
    chk("jmp wrap phase", 32'(ph_w), 32'd0);

    // en=0 at phase 2 freezes the sequencer.
    step(1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
      chk("en=0 hold phase", 32'(ph_w), 32'd2);
      chk("en=0 strobes", 32'(st_w), 32'(9'b111000000));
      clk_edge();
    end
    step(1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
    chk("en=1 resumes advance", 32'(ph_w), 32'd3);
    step(1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);

    // Randomised traffic against the behavioural model.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
           {($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7))},
           1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0,
           $urandom_range(0, 5) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/controller_seq.md
Name: controller_seq

Overview:
- Next-generation VeriRisc control unit that owns its own 8-phase sequencer; the current block decodes an externally supplied phase.
- Decodes opcode, phase and the accumulator zero flag into the nine datapath/memory strobes.
- Adds a run enable, memory wait-state handshake, latched halt with resume, a cycle-done pulse, and a parametrised opcode width with reserved-opcode handling.
- Sits between the instruction register/accumulator and the PC, ALU and memory.

Parameters:
- OPW, 3, opcode width (>=3). Bits [2:0] select the instruction. Any nonzero bit in [OPW-1:3] marks a reserved opcode.
- WAIT_EN, 1, 1 = honour mem_rdy at the completion phases; 0 = ignore mem_rdy (treated as always 1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  run enable; 0 freezes the sequencer
- opcode  in  OPW  instruction opcode from the IR
- zero  in  1  accumulator is zero
- mem_rdy  in  1  memory access complete
- resume  in  1  restart after halt (level, sampled on clk)
- sel  out  1  select PC address to memory
- rd  out  1  memory output enable onto data bus
- ld_ir  out  1  load instruction register
- inc_pc  out  1  increment PC
- halt  out  1  halt strobe
- ld_pc  out  1  load PC
- data_e  out  1  accumulator drives data bus
- ld_ac  out  1  load accumulator
- wr  out  1  memory write
- phase  out  3  current phase register
- halted  out  1  machine halted (registered)
- cycle_done  out  1  instruction retiring this cycle

Behaviour:
- Reset (rst=0, asynchronous): phase=0, halted=0. All strobes, halt and cycle_done are forced to 0 while rst=0. Release is synchronous to the next clk.
- Opcode map, using opcode[2:0]: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- Strobe decode is combinational from phase, opcode and zero.
  - Phase 0: sel. Phase 1: sel, rd. Phases 2-3: sel, rd, ld_ir.
  - Phase 4: inc_pc, plus halt if HLT.
  - Phases 5-7:
    - ADD/AND/XOR/LDA: rd at 5, 6, 7; ld_ac at 7 only.
    - STO: data_e at 6 and 7; wr at 7 only.
    - JMP: ld_pc at 6 and 7.
    - SKZ: inc_pc at 6 when zero=1.
    - HLT and reserved opcodes: no strobes.
- Phase advance occurs on each clk edge when en=1, halted=0 and the current phase is not stalled. Advance is phase+1, wrapping 7->0.
- Stall (WAIT_EN=1 only):
  - Phase 3 holds while mem_rdy=0 (instruction fetch).
  - Phase 7 holds while mem_rdy=0 for ADD/AND/XOR/LDA/STO.
  - Strobes stay asserted unchanged during a stall.
  - Phases 0-2 and 4-6 never stall. JMP, SKZ, HLT and reserved opcodes never stall at 7.
- cycle_done = 1 when phase=7 and the sequencer advances on this edge (en=1, not stalled, not halted).
- Halt:
  - Leaving phase 4 with HLT sets halted=1 on that edge; phase goes to 5 and freezes.
  - While halted: phase frozen, strobes decode to 0 (HLT at phase 5), cycle_done=0, en ignored.
  - resume=1 while halted: next edge sets halted=0, phase=0. resume while not halted has no effect.
- Reserved opcode (OPW>3, upper bits nonzero): full fetch and inc_pc at phase 4; no strobes at phases 5-7; never halts, never stalls at phase 7.
- en=0: phase holds. Strobes keep decoding the held phase. en is ignored when halted.
- Simultaneous events:
  - Reset dominates everything.
  - halted dominates en, mem_rdy and stall.
  - A stall dominates en=1.
- Reset mid-instruction (any phase, any stall or halt state): immediate return to phase 0, halted=0. The next instruction starts with a fresh fetch.

Test Plan:
- Reset: rst=0 at phase 5 of STO -> phase=0, wr=0, all strobes 0. After release with en=1, mem_rdy=1 -> sel=1 at phase 0, advancing 0..7.
- ADD, mem_rdy=1: strobe vectors {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr} per phase 0..7 = 100000000, 110000000, 111000000, 111000000, 000100000, 010000000, 010000000, 010000010. cycle_done=1 only in phase 7.
- Wait states, LDA: mem_rdy=0 for 3 cycles at phase 3 -> phase stays 3 with ld_ir=1. Then 2 cycles at phase 7 -> ld_ac=1 held, cycle_done=0 until mem_rdy=1. Total instruction length 13 clocks. Repeat with WAIT_EN=0 -> 8 clocks.
- HLT then resume: phase 4 gives 000110000. Next edge halted=1, phase=5, all strobes 0 for 10 clocks with en=1. resume=1 -> phase 0, halted=0, sel=1.
- SKZ with zero=1 -> inc_pc=1 at phase 6 only. With zero=0 -> no strobes at 5-7. JMP -> ld_pc at 6 and 7, no stall with mem_rdy=0 at phase 7.
- OPW=4, opcode=4'b1010 -> fetch and inc_pc only; phases 5-7 all strobes 0; halted stays 0. en=0 at phase 2 for 4 clocks -> phase holds at 2.
